memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage_pkg.sv | 29 ++
 rtl/memory_stage_if.sv | 52 +++++
 rtl/memory_stage_data_mem.sv | 24 ++
 rtl/memory_stage.sv | 137 +++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// Shared encodings and byte-lane constants for the memory stage.
package mem_pkg;

  localparam int BYTE_LANES = 4;
  localparam int WORD_BITS  = 32;

  // Byte-enable patterns for one 32-bit word.
  localparam logic [BYTE_LANES-1:0] BE_NONE    = 4'b0000;
  localparam logic [BYTE_LANES-1:0] BE_BYTE0   = 4'b0001;
  localparam logic [BYTE_LANES-1:0] BE_HALF_LO = 4'b0011;
  localparam logic [BYTE_LANES-1:0] BE_HALF_HI = 4'b1100;
  localparam logic [BYTE_LANES-1:0] BE_WORD    = 4'b1111;

  // Load and store share funct3 values, so they live in separate enums.
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_f3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_f3_e;

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory port bundle, plus the M-to-W pipeline bundle used by benches.
interface memory_stage_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  we;
  logic [3:0]            be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [31:0]           wdata;
  logic [31:0]           rdata;

  modport master (output we, be, addr, wdata, input rdata);
  modport slave  (input we, be, addr, wdata, output rdata);
endinterface

// M-stage request fields and the registered W-stage result fields.
// There is no valid/ready pair: every cycle carries an instruction, stall_w
// freezes the W register and flush_w replaces it with a bubble.
interface memory_stage_pipe_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
);
  logic                      reg_write_m;
  logic                      result_src_m;
  logic                      mem_write_m;
  logic [2:0]                funct3_m;
  logic [DATA_WIDTH-1:0]     alu_result_m;
  logic [DATA_WIDTH-1:0]     write_data_m;
  logic [REG_ADDR_WIDTH-1:0] rd_m;
  logic [DATA_WIDTH-1:0]     pc_plus4_m;
  logic                      stall_w;
  logic                      flush_w;
  logic                      reg_write_w;
  logic                      result_src_w;
  logic [DATA_WIDTH-1:0]     read_data_w;
  logic [DATA_WIDTH-1:0]     alu_result_w;
  logic [REG_ADDR_WIDTH-1:0] rd_w;
  logic [DATA_WIDTH-1:0]     pc_plus4_w;
  logic                      mem_err_w;

  modport master (
    output reg_write_m, result_src_m, mem_write_m, funct3_m, alu_result_m,
           write_data_m, rd_m, pc_plus4_m, stall_w, flush_w,
    input  reg_write_w, result_src_w, read_data_w, alu_result_w, rd_w,
           pc_plus4_w, mem_err_w
  );
  modport slave (
    input  reg_write_m, result_src_m, mem_write_m, funct3_m, alu_result_m,
           write_data_m, rd_m, pc_plus4_m, stall_w, flush_w,
    output reg_write_w, result_src_w, read_data_w, alu_result_w, rd_w,
           pc_plus4_w, mem_err_w
  );
endinterface

// File: rtl/memory_stage_data_mem.sv
// Word-organised data RAM: byte-enabled synchronous write, combinational read.
module data_mem
  import mem_pkg::*;
#(
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input logic           clk,
  memory_stage_if.slave bus
);

  logic [WORD_BITS-1:0] ram [MEM_DEPTH_WORDS];

  // Commit enabled byte lanes of the addressed word; other lanes keep their value.
  always_ff @(posedge clk) begin
    if (bus.we) begin
      for (int i = 0; i < BYTE_LANES; i++) begin
        if (bus.be[i]) ram[bus.addr][8*i +: 8] <= bus.wdata[8*i +: 8];
      end
    end
  end

  assign bus.rdata = ram[bus.addr];

endmodule

// File: rtl/memory_stage.sv
// Pipeline memory stage: access decode, alignment check, load extension
// and the M/W pipeline register in front of writeback.
module memory_stage
  import mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int REG_ADDR_WIDTH  = 4,
  parameter int MEM_DEPTH_WORDS = 1024
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      RegWriteM_i,
  input  logic                      ResultSrcM_i,
  input  logic                      MemWriteM_i,
  input  logic [2:0]                Funct3M_i,
  input  logic [DATA_WIDTH-1:0]     ALUResultM_i,
  input  logic [DATA_WIDTH-1:0]     WriteDataM_i,
  input  logic [REG_ADDR_WIDTH-1:0] RdM_i,
  input  logic [DATA_WIDTH-1:0]     PCPlus4M_i,
  input  logic                      StallW_i,
  input  logic                      FlushW_i,
  output logic                      RegWriteW_o,
  output logic                      ResultSrcW_o,
  output logic [DATA_WIDTH-1:0]     ReadDataW_o,
  output logic [DATA_WIDTH-1:0]     ALUResultW_o,
  output logic [REG_ADDR_WIDTH-1:0] RdW_o,
  output logic [DATA_WIDTH-1:0]     PCPlus4W_o,
  output logic                      MemErrW_o
);

  localparam int AW = $clog2(MEM_DEPTH_WORDS);

  memory_stage_if #(.ADDR_WIDTH(AW)) dmem ();

  data_mem #(.MEM_DEPTH_WORDS(MEM_DEPTH_WORDS)) u_data_mem (
    .clk (clk),
    .bus (dmem.slave)
  );

  logic [1:0]            addr_lo;
  logic                  store_ok;
  logic                  load_ok;
  logic                  mem_err;
  logic [3:0]            store_be;
  logic [31:0]           store_data;
  logic [7:0]            byte_sel;
  logic [15:0]           half_sel;
  logic [DATA_WIDTH-1:0] load_ext;

  assign addr_lo  = ALUResultM_i[1:0];
  assign byte_sel = dmem.rdata[{addr_lo, 3'b000} +: 8];
  assign half_sel = dmem.rdata[{addr_lo[1], 4'b0000} +: 16];

  // Store decode: legality, lane enables and lane-replicated write data.
  always_comb begin
    store_ok   = 1'b0;
    store_be   = BE_NONE;
    store_data = WriteDataM_i[31:0];
    case (Funct3M_i)
      SB: begin
        store_ok   = 1'b1;
        store_be   = BE_BYTE0 << addr_lo;
        store_data = {4{WriteDataM_i[7:0]}};
      end
      SH: begin
        store_ok   = ~addr_lo[0];
        store_be   = addr_lo[1] ? BE_HALF_HI : BE_HALF_LO;
        store_data = {2{WriteDataM_i[15:0]}};
      end
      SW: begin
        store_ok = (addr_lo == 2'b00);
        store_be = BE_WORD;
      end
      default: ;
    endcase
  end

  // Load decode: legality and sign/zero extension of the selected lane.
  always_comb begin
    load_ok  = 1'b0;
    load_ext = '0;
    case (Funct3M_i)
      LB: begin
        load_ok  = 1'b1;
        load_ext = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      end
      LH: begin
        load_ok  = ~addr_lo[0];
        load_ext = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      end
      LW: begin
        load_ok  = (addr_lo == 2'b00);
        load_ext = DATA_WIDTH'(dmem.rdata);
      end
      LBU: begin
        load_ok  = 1'b1;
        load_ext = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      end
      LHU: begin
        load_ok  = ~addr_lo[0];
        load_ext = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      end
      default: ;
    endcase
  end

  // The error only matters for instructions that actually touch memory.
  assign mem_err = (MemWriteM_i & ~store_ok) | (ResultSrcM_i & ~load_ok);

  // Reads are combinational, so a store+load reads the word before this edge's write.
  assign dmem.addr  = ALUResultM_i[AW+1:2];
  assign dmem.be    = store_be;
  assign dmem.wdata = store_data;
  assign dmem.we    = MemWriteM_i & store_ok & ~StallW_i & ~FlushW_i & rst_n;

  // W register: reset beats flush, flush beats stall.
  always_ff @(posedge clk) begin
    if (!rst_n || FlushW_i) begin
      RegWriteW_o  <= 1'b0;
      ResultSrcW_o <= 1'b0;
      ReadDataW_o  <= '0;
      ALUResultW_o <= '0;
      RdW_o        <= '0;
      PCPlus4W_o   <= '0;
      MemErrW_o    <= 1'b0;
    end else if (!StallW_i) begin
      RegWriteW_o  <= RegWriteM_i;
      ResultSrcW_o <= ResultSrcM_i;
      ReadDataW_o  <= mem_err ? '0 : load_ext;
      ALUResultW_o <= ALUResultM_i;
      RdW_o        <= RdM_i;
      PCPlus4W_o   <= PCPlus4M_i;
      MemErrW_o    <= mem_err;
    end
  end

endmodule
